// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory access using a req/gnt handshake followed by
// an rvalid response, with byte-lane steering, load extraction and misalignment trapping.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      funct3_i,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            misaligned_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            is_load_q, is_load_d;
    logic            is_store_q, is_store_d;
    logic            misaligned_q, misaligned_d;

    logic            illegal;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] extracted;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    // Legality is judged on the incoming request, before it is registered.
    always_comb begin
        illegal = 1'b0;
        case (funct3_i[1:0])
            2'b01:   if (addr_i[0]) illegal = 1'b1;
            2'b10:   if (addr_i[1:0] != 2'b00) illegal = 1'b1;
            2'b11:   illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
        if (is_store_i && funct3_i[2]) illegal = 1'b1;
        if (is_load_i && funct3_i == 3'b110) illegal = 1'b1;
        if (is_load_i && is_store_i) illegal = 1'b1;
    end

    always_comb begin
        be    = 4'b1111;
        wdata = sdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wdata = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_q[1:0];
                wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = sdata_q;
            end
        endcase
    end

    // funct3[2] selects zero-extension for sub-word loads.
    always_comb begin
        rbyte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        rhalf = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q[1:0])
            2'b00:   extracted = funct3_q[2] ? {{(XLEN-8){1'b0}}, rbyte}
                                             : {{(XLEN-8){rbyte[7]}}, rbyte};
            2'b01:   extracted = funct3_q[2] ? {{(XLEN-16){1'b0}}, rhalf}
                                             : {{(XLEN-16){rhalf[15]}}, rhalf};
            default: extracted = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        funct3_d     = funct3_q;
        is_load_d    = is_load_q;
        is_store_d   = is_store_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    addr_d     = addr_i;
                    sdata_d    = store_data_i;
                    funct3_d   = funct3_i;
                    is_load_d  = is_load_i;
                    is_store_d = is_store_i;
                    if (!is_load_i && !is_store_i) begin
                        state_d      = DONE;
                        load_data_d  = '0;
                        misaligned_d = 1'b0;
                    end else if (illegal) begin
                        state_d      = DONE;
                        load_data_d  = '0;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A response arriving in the grant cycle itself is not sampled.
                if (mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d      = DONE;
                    load_data_d  = is_load_q ? extracted : '0;
                    misaligned_d = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            sdata_q      <= '0;
            funct3_q     <= '0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sdata_q      <= sdata_d;
            funct3_q     <= funct3_d;
            is_load_q    <= is_load_d;
            is_store_q   <= is_store_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Memory-side outputs are driven only while requesting, so they read zero otherwise.
    assign mem_req_o    = (state_q == REQ);
    assign mem_we_o     = mem_req_o & is_store_q;
    assign mem_addr_o   = mem_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_be_o     = mem_req_o ? be : 4'b0000;
    assign mem_wdata_o  = mem_req_o ? wdata : '0;
    assign out_valid_o  = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign load_data_o  = load_data_q;
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: expected completions are queued when a
// request is driven and compared when the unit pulses out_valid.
module tb_load_store_unit;

    typedef struct packed {
        logic [31:0] ld;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        inValid = 1'b0;
    logic        isLoad = 1'b0;
    logic        isStore = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] storeData = 32'h0;
    logic [2:0]  funct3 = 3'b000;
    logic        memGnt = 1'b0;
    logic        memRvalid = 1'b0;
    logic [31:0] memRdata = 32'h0;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        outValid;
    logic [31:0] loadData;
    logic        misaligned;
    logic        busy;

    int   checkCount = 0;
    int   passCount = 0;
    exp_t sb[$];

    load_store_unit dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .in_valid_i   (inValid),
        .is_load_i    (isLoad),
        .is_store_i   (isStore),
        .addr_i       (addr),
        .store_data_i (storeData),
        .funct3_i     (funct3),
        .mem_req_o    (memReq),
        .mem_gnt_i    (memGnt),
        .mem_we_o     (memWe),
        .mem_addr_o   (memAddr),
        .mem_be_o     (memBe),
        .mem_wdata_o  (memWdata),
        .mem_rvalid_i (memRvalid),
        .mem_rdata_i  (memRdata),
        .out_valid_o  (outValid),
        .load_data_o  (loadData),
        .misaligned_o (misaligned),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * off);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return (4'b0001 << off) | (4'b0010 << off);
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] sz, input logic [31:0] sd);
        case (sz)
            2'b00:   return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            2'b01:   return {sd[15:0], sd[15:0]};
            default: return sd;
        endcase
    endfunction

    // Scoreboard side: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstN && outValid) begin
            if (sb.size() == 0) begin
                checkOutput("spuriousDone", {31'b0, outValid}, 32'h0);
            end else begin
                e = sb.pop_front();
                checkOutput("loadData", loadData, e.ld);
                checkOutput("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
            end
        end
    end

    // Drives one request at a negedge and plays the memory side with a given grant delay.
    // A second in_valid is injected during a delayed grant; dualPulse raises rvalid in the
    // grant cycle with wrong data, which the unit must not take as the response.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int gntDelay,
                                 input logic dualPulse, input logic [31:0] expLd,
                                 input logic expMis, input logic expAccess,
                                 input logic [3:0] expBe, input logic [31:0] expWdata);
        exp_t e;
        e.ld  = expLd;
        e.mis = expMis;
        sb.push_back(e);
        isLoad    = ld;
        isStore   = st;
        funct3    = f3;
        addr      = a;
        storeData = sd;
        inValid   = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        isLoad  = 1'b0;
        isStore = 1'b0;
        if (!expAccess) begin
            checkOutput("noMemReq", {31'b0, memReq}, 32'h0);
            checkOutput("earlyDone", {31'b0, outValid}, 32'h1);
        end else begin
            for (int c = 0; c <= gntDelay; c++) begin
                checkOutput("memReq", {31'b0, memReq}, 32'h1);
                checkOutput("memWe", {31'b0, memWe}, {31'b0, st});
                checkOutput("memAddr", memAddr, {a[31:2], 2'b00});
                checkOutput("memBe", {28'b0, memBe}, {28'b0, expBe});
                if (st) checkOutput("memWdata", memWdata, expWdata);
                if (c == gntDelay) begin
                    memGnt = 1'b1;
                    if (dualPulse) begin
                        memRvalid = 1'b1;
                        memRdata  = ~rd;
                    end
                end else if (c == 0) begin
                    inValid = 1'b1;
                    isLoad  = 1'b1;
                    funct3  = 3'b010;
                    addr    = a + 32'h100;
                end
                @(negedge clk);
                inValid = 1'b0;
                isLoad  = 1'b0;
                isStore = 1'b0;
            end
            memGnt    = 1'b0;
            memRvalid = 1'b0;
            checkOutput("reqDropped", {31'b0, memReq}, 32'h0);
            checkOutput("waitNoDone", {31'b0, outValid}, 32'h0);
            memRvalid = 1'b1;
            memRdata  = rd;
            @(negedge clk);
            memRvalid = 1'b0;
            memRdata  = $urandom();
            checkOutput("doneLatency", {31'b0, outValid}, 32'h1);
        end
        @(negedge clk);
        checkOutput("singlePulse", {31'b0, outValid}, 32'h0);
        checkOutput("holdLoadData", loadData, expLd);
        checkOutput("holdMisaligned", {31'b0, misaligned}, {31'b0, expMis});
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic        rLd;
        logic        rUns;
        logic [1:0]  rSz;
        logic [2:0]  rF3;
        logic [31:0] rA;
        logic [31:0] rSd;
        logic [31:0] rRd;

        #1 rstN = 1'b0;
        #2;
        checkOutput("rstBusy", {31'b0, busy}, 32'h0);
        checkOutput("rstMemReq", {31'b0, memReq}, 32'h0);
        checkOutput("rstOutValid", {31'b0, outValid}, 32'h0);
        checkOutput("rstLoadData", loadData, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Directed cases: examples, illegal encodings, a no-op and the response/grant overlap.
        applyStimulus(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1122, 0, 0,
                      32'hFFFF_FF80, 0, 1, 4'b1000, 32'h0);
        applyStimulus(1, 0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 0,
                      32'h0000_BEEF, 0, 1, 4'b1100, 32'h0);
        applyStimulus(0, 1, 3'b000, 32'h11, 32'h1234_56AB, 32'h7777_7777, 0, 1,
                      32'h0, 0, 1, 4'b0010, 32'hABAB_ABAB);
        applyStimulus(1, 0, 3'b010, 32'h6, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 4'b0, 32'h0);
        applyStimulus(0, 1, 3'b010, 32'h40, 32'hCAFE_F00D, 32'h0, 3, 0,
                      32'h0, 0, 1, 4'b1111, 32'hCAFE_F00D);
        applyStimulus(0, 1, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 4'b0, 32'h0);
        applyStimulus(1, 0, 3'b011, 32'h8, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 4'b0, 32'h0);
        applyStimulus(0, 1, 3'b100, 32'h4, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 4'b0, 32'h0);
        applyStimulus(1, 0, 3'b110, 32'h8, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 4'b0, 32'h0);
        applyStimulus(1, 1, 3'b010, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 4'b0, 32'h0);
        applyStimulus(0, 0, 3'b010, 32'h10, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 4'b0, 32'h0);
        applyStimulus(1, 0, 3'b001, 32'h0, 32'h0, 32'h1234_8001, 0, 1,
                      32'hFFFF_8001, 0, 1, 4'b0011, 32'h0);
        applyStimulus(1, 0, 3'b010, 32'h4, 32'h0, 32'hDEAD_BEEF, 1, 0,
                      32'hDEAD_BEEF, 0, 1, 4'b1111, 32'h0);

        // Reset while waiting for a response; the late response must be dropped.
        isLoad  = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h20;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        isLoad  = 1'b0;
        checkOutput("rstPreReq", {31'b0, memReq}, 32'h1);
        memGnt = 1'b1;
        @(negedge clk);
        memGnt = 1'b0;
        checkOutput("rstPreWait", {31'b0, busy}, 32'h1);
        rstN = 1'b0;
        #1;
        checkOutput("rstMidBusy", {31'b0, busy}, 32'h0);
        checkOutput("rstMidReq", {31'b0, memReq}, 32'h0);
        checkOutput("rstMidWe", {31'b0, memWe}, 32'h0);
        checkOutput("rstMidAddr", memAddr, 32'h0);
        checkOutput("rstMidBe", {28'b0, memBe}, 32'h0);
        checkOutput("rstMidWdata", memWdata, 32'h0);
        checkOutput("rstMidOutValid", {31'b0, outValid}, 32'h0);
        checkOutput("rstMidLoadData", loadData, 32'h0);
        checkOutput("rstMidMisaligned", {31'b0, misaligned}, 32'h0);
        @(negedge clk);
        rstN      = 1'b1;
        memRvalid = 1'b1;
        memGnt    = 1'b1;
        memRdata  = 32'h5555_AAAA;
        @(negedge clk);
        memRvalid = 1'b0;
        memGnt    = 1'b0;
        checkOutput("lateRvalidOut", {31'b0, outValid}, 32'h0);
        checkOutput("lateRvalidBusy", {31'b0, busy}, 32'h0);
        checkOutput("lateRvalidData", loadData, 32'h0);
        @(negedge clk);
        checkOutput("stayIdleOut", {31'b0, outValid}, 32'h0);
        checkOutput("stayIdleBusy", {31'b0, busy}, 32'h0);

        // Randomised legal accesses checked against the reference model.
        for (int i = 0; i < 16; i++) begin
            rLd  = 1'($urandom_range(0, 1));
            rUns = 1'($urandom_range(0, 1));
            rSz  = 2'($urandom_range(0, 2));
            rF3  = {(rLd && rSz != 2'b10) ? rUns : 1'b0, rSz};
            rA   = $urandom() & 32'hFFFF_FFF0;
            case (rSz)
                2'b00:   rA[1:0] = 2'($urandom_range(0, 3));
                2'b01:   rA[1:0] = {1'($urandom_range(0, 1)), 1'b0};
                default: rA[1:0] = 2'b00;
            endcase
            rSd = $urandom();
            rRd = $urandom();
            applyStimulus(rLd, !rLd, rF3, rA, rSd, rRd, int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)),
                          rLd ? modelLoad(rF3, rA[1:0], rRd) : 32'h0, 1'b0, 1'b1,
                          modelBe(rSz, rA[1:0]), modelWdata(rSz, rSd));
        end

        checkOutput("scoreboardDrained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
